// File: rtl/riscv_fetch_queue_if.sv
// rtl/riscv_fetch_queue_if.sv - instruction memory and decode handshake bundle for the fetch queue
interface riscv_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_ins;
    logic            out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_ins,
        input  imem_gnt, imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_ins,
        output imem_gnt, imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - in-order instruction fetch queue with variable-latency memory and redirect flush
module riscv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    riscv_fetch_queue_if.master    bus,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t            alloc_ptr_q, alloc_ptr_d;
    ptr_t            fill_ptr_q, fill_ptr_d;
    ptr_t            head_ptr_q, head_ptr_d;
    cnt_t            occ_q, occ_d;
    cnt_t            pend_q, pend_d;
    cnt_t            drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [XLEN-1:0] ins_q [DEPTH];
    logic [XLEN-1:0] ins_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;

    logic req, grant, resp_fill, resp_drop, out_valid, pop;

    // Request never looks at out_ready, so decode cannot create a path into the memory port.
    assign req       = !rst && !redirect_valid && (occ_q < cnt_t'(DEPTH));
    assign grant     = req && bus.imem_gnt;
    assign resp_drop = bus.imem_rvalid && (drop_cnt_q != '0);
    assign resp_fill = bus.imem_rvalid && (drop_cnt_q == '0) && (pend_q != '0);
    assign out_valid = !rst && !redirect_valid && filled_q[head_ptr_q];
    assign pop       = out_valid && bus.out_ready;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = pc_q[head_ptr_q];
    assign bus.out_ins   = ins_q[head_ptr_q];
    assign occupancy     = occ_q;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        occ_d       = occ_q;
        pend_d      = pend_q;
        drop_cnt_d  = drop_cnt_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        filled_d    = filled_q;

        if (redirect_valid) begin
            fetch_pc_d  = redirect_pc & ~(XLEN'(3));
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            occ_d       = '0;
            pend_d      = '0;
            filled_d    = '0;
            // Every request still in flight must be swallowed, minus the one returning right now.
            drop_cnt_d  = drop_cnt_q + pend_q
                        - cnt_t'(bus.imem_rvalid && ((drop_cnt_q != '0) || (pend_q != '0)));
        end else begin
            if (grant) begin
                pc_d[alloc_ptr_q]     = fetch_pc_q;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + ptr_t'(1);
                fetch_pc_d            = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (resp_fill) begin
                ins_d[fill_ptr_q]    = bus.imem_rdata;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + ptr_t'(1);
            end
            occ_d  = occ_q + cnt_t'(grant) - cnt_t'(pop);
            pend_d = pend_q + cnt_t'(grant) - cnt_t'(resp_fill);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            occ_q       <= '0;
            pend_q      <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            occ_q       <= occ_d;
            pend_q      <= pend_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
        end
    end

    // A response with nothing outstanding and nothing to drop means the memory broke ordering.
    resp_protocol: assert property (@(posedge CLK) disable iff (rst)
        !(bus.imem_rvalid && (drop_cnt_q == '0) && (pend_q == '0)));
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - scoreboard bench for riscv_fetch_queue with a variable-latency memory model
module tb_riscv_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;

    riscv_fetch_queue_if #(.XLEN(XLEN)) bus ();

    riscv_fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    mreq_t mq[$];
    exp_t  exp_q[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    mem_lat = 1;
    bit    rand_lat = 1'b0;
    logic [31:0] ref_pc = RESET_PC;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model plus reference fetch-PC model; pushes expected entries on every grant.
    always @(negedge CLK) begin
        #1;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            ref_pc = RESET_PC;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = img(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
            end
            if (redirect_valid) begin
                exp_q.delete();
                ref_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (bus.imem_req && bus.imem_gnt) begin
                check("grant_addr", bus.imem_addr, ref_pc);
                exp_q.push_back('{pc: ref_pc, ins: img(ref_pc)});
                mq.push_back('{addr: bus.imem_addr,
                               due: cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat)});
                ref_pc = ref_pc + 32'd4;
            end
        end
    end

    // Monitor: pops the scoreboard whenever decode accepts an instruction.
    logic [31:0] last_pc;
    bit          have_last = 1'b0;
    always @(negedge CLK) begin
        #2;
        if (rst || redirect_valid) begin
            have_last = 1'b0;
        end else begin
            tests++;
            if (occupancy > 3'(DEPTH)) begin
                fails++;
                $display("FAIL occ_bound: got %0d expected <= %0d", occupancy, DEPTH);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got pc %h expected no output", bus.out_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc", bus.out_pc, e.pc);
                    check("sb_ins", bus.out_ins, e.ins);
                end
                if (have_last) check("pc_step", bus.out_pc, last_pc + 32'd4);
                last_pc   = bus.out_pc;
                have_last = 1'b1;
            end
        end
    end

    task automatic restart();
        @(negedge CLK);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic wait_out_pc(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            #3;
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no out_valid expected pc %h", name, exp_pc);
        end else begin
            check(name, bus.out_pc, exp_pc);
        end
    endtask

    initial begin
        int grants;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.imem_gnt = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_req", bus.imem_req, 0);

        // Streaming, latency 1
        bus.imem_gnt = 1'b1;
        bus.out_ready = 1'b1;
        mem_lat = 1;
        @(negedge CLK);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            #3;
            check("t1_req", bus.imem_req, 1);
            check("t1_addr", bus.imem_addr, 32'(4 * i));
            if (i >= 2) begin
                check("t1_valid", bus.out_valid, 1);
                check("t1_out_pc", bus.out_pc, 32'(4 * (i - 2)));
            end
        end

        // Fill to DEPTH with decode stalled, then drain
        bus.out_ready = 1'b0;
        restart();
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            #3;
            if (bus.imem_req && bus.imem_gnt) grants++;
        end
        check("t2_grants", grants, 4);
        check("t2_full_occ", occupancy, 4);
        check("t2_full_req", bus.imem_req, 0);
        @(negedge CLK);
        bus.out_ready = 1'b1;
        #3;
        check("t2_pop_valid", bus.out_valid, 1);
        check("t2_pop_pc", bus.out_pc, 32'h0);
        check("t2_pop_req", bus.imem_req, 0);
        @(negedge CLK);
        #3;
        check("t2_after_occ", occupancy, 3);
        check("t2_after_req", bus.imem_req, 1);
        check("t2_after_pc", bus.out_pc, 32'h4);

        // Redirect with two requests in flight, latency 3
        mem_lat = 3;
        restart();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(negedge CLK);
        redirect_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        #3;
        check("t3_occ", occupancy, 2);
        check("t3_valid", bus.out_valid, 0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #3;
        check("t3_addr", bus.imem_addr, 32'h200);
        check("t3_req", bus.imem_req, 1);
        wait_out_pc("t3_first_pc", 32'h200);

        // Redirect coinciding with the response for 0x10, one more pending
        restart();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(negedge CLK);
        redirect_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        bus.imem_gnt = 1'b0;
        @(negedge CLK);
        bus.imem_gnt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        #3;
        check("t4_rvalid", bus.imem_rvalid, 1);
        check("t4_valid", bus.out_valid, 0);
        @(negedge CLK);
        redirect_valid = 1'b0;
        #3;
        check("t4_valid_next", bus.out_valid, 0);
        check("t4_occ", occupancy, 0);
        check("t4_addr", bus.imem_addr, 32'h300);
        wait_out_pc("t4_first_pc", 32'h300);

        // Reset mid-stream with three entries buffered
        mem_lat = 1;
        bus.out_ready = 1'b0;
        restart();
        grants = 0;
        for (int i = 0; i < 10 && grants == 0; i++) begin
            if (i > 0) @(negedge CLK);
            #3;
            if (occupancy == 3'd2) grants = 1;
        end
        check("t6_reach", grants, 1);
        @(negedge CLK);
        rst = 1'b1;
        #3;
        check("t6_pre_occ", occupancy, 3);
        check("t6_pre_req", bus.imem_req, 0);
        @(negedge CLK);
        #3;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_req", bus.imem_req, 0);
        @(negedge CLK);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("t6_rel_addr", bus.imem_addr, RESET_PC);
        check("t6_rel_req", bus.imem_req, 1);
        repeat (6) @(negedge CLK);

        // Random grant stalls, decode stalls and redirects
        rand_lat = 1'b1;
        restart();
        for (int i = 0; i < 10000; i++) begin
            if (i > 0) @(negedge CLK);
            bus.imem_gnt   = ($urandom_range(0, 3) != 0);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 99) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE1 | 32'($urandom_range(0, 31)))
                                                         : $urandom;
        end
        @(negedge CLK);
        redirect_valid = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) @(negedge CLK);
        #3;
        check("rand_drained", exp_q.size(), 0);
        check("rand_occ", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end
endmodule
